// File: rtl/mem_pkg.sv
// Shared memory-op encodings, FSM states and error causes for the load/store stage.
package mem_pkg;
  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP, ST_ERR} state_e;

  typedef struct packed {
    logic                          we;
    logic [2:0]                    funct3;
    logic [1:0]                    off;
    logic [NUM_LANES-1:0]          wstrb;
    logic [NUM_LANES-1:0][7:0]     wdata;
  } acc_req_t;

  // Illegal encodings take priority over alignment faults.
  function automatic logic [1:0] classify(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [1:0] a);
    logic legal_ld, legal_st;
    legal_ld = (f3 == MEMOP_B) || (f3 == MEMOP_H) || (f3 == MEMOP_W) ||
               (f3 == MEMOP_BU) || (f3 == MEMOP_HU);
    legal_st = (f3 == MEMOP_B) || (f3 == MEMOP_H) || (f3 == MEMOP_W);
    if (rd && wr)                                   return ERR_ILLEGAL;
    if (wr && !legal_st)                            return ERR_ILLEGAL;
    if (rd && !legal_ld)                            return ERR_ILLEGAL;
    if ((f3 == MEMOP_H || f3 == MEMOP_HU) && a[0])  return ERR_MISALIGN;
    if (f3 == MEMOP_W && a != 2'b00)                return ERR_MISALIGN;
    return ERR_NONE;
  endfunction
endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Selects a byte/half/word from a bus word by byte offset and extends it per funct3.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] ext_data
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = mem_rdata[8*offset +: 8];
  assign h = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ext_data = mem_rdata;
    case (funct3)
      MEMOP_B:  ext_data = {{24{b[7]}}, b};
      MEMOP_H:  ext_data = {{16{h[15]}}, h};
      MEMOP_BU: ext_data = {24'h0, b};
      MEMOP_HU: ext_data = {16'h0, h};
      default:  ext_data = mem_rdata;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: classifies the decoder request, runs one bus transfer with
// req/ready handshake and timeout, and returns extended load data.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_cause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e                    state, nxt;
  acc_req_t                  req_q, req_d;
  logic [ADDR_W-1:0]         addr_q;
  logic [CNT_W-1:0]          cnt;
  logic [1:0]                cause_d;
  logic [31:0]               ld_ext;
  logic [NUM_LANES-1:0][7:0] wdata_rep;
  logic                      any_req, timeout_hit;

  assign any_req     = MemRd | MemWr;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // Lane replication: bytes go to every lane, halves to both half-lanes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wdata_rep[i] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                          (funct3[1:0] == 2'b01) ? wdata[8*(i%2) +: 8] :
                                                   wdata[8*i +: 8];
  end

  always_comb begin
    req_d        = '0;
    req_d.we     = MemWr;
    req_d.funct3 = funct3;
    req_d.off    = addr[1:0];
    req_d.wdata  = wdata_rep;
    if (MemWr) begin
      case (funct3[1:0])
        2'b00:   req_d.wstrb = 4'b0001 << addr[1:0];
        2'b01:   req_d.wstrb = 4'b0011 << {addr[1], 1'b0};
        default: req_d.wstrb = 4'b1111;
      endcase
    end
  end

  load_extend u_load_extend (
    .mem_rdata (mem_rdata),
    .offset    (req_q.off),
    .funct3    (req_q.funct3),
    .ext_data  (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      addr_q    <= '0;
      cnt       <= '0;
      rdata     <= '0;
      err_cause <= ERR_NONE;
    end else begin
      state <= nxt;
      case (state)
        ST_IDLE: if (any_req) begin
          err_cause <= cause_d;
          if (cause_d == ERR_NONE) begin
            req_q  <= req_d;
            addr_q <= {addr[ADDR_W-1:2], 2'b00};
            cnt    <= '0;
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            if (!req_q.we) rdata <= ld_ext;
          end else if (timeout_hit) begin
            err_cause <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt     = state;
    cause_d = ERR_NONE;
    case (state)
      ST_IDLE: if (any_req) begin
        cause_d = classify(MemRd, MemWr, funct3, addr[1:0]);
        nxt     = (cause_d == ERR_NONE) ? ST_ACCESS : ST_ERR;
      end
      ST_ACCESS: begin
        if (mem_ready)        nxt = ST_RESP;
        else if (timeout_hit) nxt = ST_ERR;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Stall is gated by reset so every output reads 0 while rst_n is low.
  always_comb begin
    stall   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    mem_req = 1'b0;
    case (state)
      ST_IDLE:   stall = rst_n & any_req;
      ST_ACCESS: begin stall = 1'b1; mem_req = 1'b1; end
      ST_RESP:   done = 1'b1;
      ST_ERR:    begin done = 1'b1; err = 1'b1; end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_we    = mem_req & req_q.we;
  assign mem_wstrb = mem_req ? req_q.wstrb : 4'b0000;
  assign mem_wdata = req_q.wdata;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the control decoder in the single-cycle RISC-V core.
- Consumes MemRd/MemWr, funct3 and the ALU-computed address. Drives a word-wide data-memory bus with a req/ready handshake.
- Stalls the core until the access completes and returns the sign- or zero-extended load data for the MemtoReg mux.
- Detects misaligned accesses, illegal encodings and bus timeouts.

Parameters:
ADDR_W, 32, byte-address width of the CPU address and the memory bus.
TIMEOUT, 16, maximum ACCESS cycles without mem_ready before a timeout error; must be ≥1.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
MemRd  in  1  load request from the decoder
MemWr  in  1  store request from the decoder
funct3  in  3  access size and sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data (busB)
rdata  out  32  extended load result, valid while done=1
stall  out  1  hold PC and register writes this cycle
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, coincident with done
err_cause  out  2  01 misaligned, 10 illegal, 11 timeout; held until the next accepted request
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
mem_wstrb  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_ready  in  1  bus completion; read data valid in the same cycle
mem_rdata  in  32  bus read word

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, timeout counter 0. mem_req drops immediately, including mid-ACCESS; an in-flight bus transfer is abandoned.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - stall = MemRd|MemWr (combinational). done=0, err=0.
  - On a clock edge with a request present, classify it:
    - MemRd&MemWr both high, or funct3 ∉ legal set (stores: 000/001/010 only) → ERR, cause 10.
    - Half access with addr[0]=1, or word access with addr[1:0]≠0 → ERR, cause 01.
    - Otherwise → ACCESS. Register mem_addr={addr[ADDR_W-1:2],2'b00}, mem_we, funct3, byte offset, strobes and write data.
- Store lane rules:
  - sb: wdata[7:0] replicated ×4, wstrb = 0001<<addr[1:0].
  - sh: wdata[15:0] ×2, wstrb = 0011<<(2·addr[1]).
  - sw: wstrb = 1111.
  - Loads: wstrb = 0000.
- ACCESS:
  - mem_req=1, stall=1. Bus outputs stay stable until ready.
  - Counter increments each cycle without mem_ready.
  - mem_ready=1: drop mem_req next edge, capture extended read data (loads) into rdata, → RESP.
  - mem_ready=0 with counter = TIMEOUT-1: → ERR, cause 11. If mem_ready and timeout coincide, ready wins.
- RESP: stall=0, done=1. rdata valid (stores leave rdata unchanged). → IDLE unconditionally, even though MemRd/MemWr are still high for the retiring instruction.
- ERR: stall=0, done=1, err=1. No memory write has occurred. → IDLE.
- Load extraction: select byte/half from mem_rdata by offset.
  - lb/lh: sign-extend.
  - lbu/lhu: zero-extend.
  - lw: pass through.
- Latency: zero-wait bus gives stall in 2 cycles and done in the 3rd. Each bus wait cycle adds 1. Errors detected in IDLE give stall 1 cycle, done in the 2nd.
- Counter clears on entry to ACCESS.

Decomposition:
- Shared package (mem_pkg):
  - funct3 memop constants (MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU).
  - State enum.
  - err_cause constants (ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT).
- One combinational sub-module, load_extend: inputs mem_rdata, offset[1:0], funct3; output 32-bit extended word. Reused by the later debug/VGA memory reader.

Test Plan:
- lw, addr=0x104, mem_rdata=0xDEADBEEF, ready in 1st ACCESS cycle → mem_addr=0x104, stall 2 cycles, then done with rdata=0xDEADBEEF.
- lb addr=0x203 then lbu addr=0x203, mem_rdata=0x80FF0011 → rdata=0xFFFFFF80, then 0x00000080.
- sh addr=0x12, wdata=0x0000A5C3 → mem_we=1, mem_wstrb=1100, mem_wdata=0xA5C3A5C3, mem_addr=0x10.
- lw addr=0x102 → no mem_req, next cycle done=err=1, err_cause=01. sb with funct3=100 → err_cause=10.
- sw with mem_ready held 0, TIMEOUT=16 → mem_req high exactly 16 cycles, then err with cause 11. Repeat with ready asserted in the 16th cycle → RESP, no err.
- rst_n pulled low in the 2nd ACCESS cycle → mem_req and stall go 0 immediately. After release, a fresh lw completes normally.
